reg_writeback_file: RTL and testbench
=====================================

Name: reg_writeback_file

Overview:
- Register-write consumer placed directly downstream of the destination-register select mux.
- Takes the selected 5-bit destination (reg_write), the write enable and the write-back data sources, and registers them in a one-entry write-back latch.
- Commits the latched write into a 32 x 32-bit register file.
- Provides two combinational read ports with bypass from the pending latch, so the decode stage sees a write the cycle after it is presented.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32
- LINK_REG, 31, register index written by jump-and-link (informational; the address arrives already selected)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- reg_write  input  ADDR_W  destination register from the destination-register mux
- RegWrite  input  1  write request for the current instruction
- MemtoReg  input  2  write-data select: 00 alu_result, 01 mem_data, 10 pc_plus4, 11 alu_result
- alu_result  input  DATA_W  ALU output
- mem_data  input  DATA_W  data-memory read data
- pc_plus4  input  DATA_W  return address for link writes
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address
- rs_data  output  DATA_W  read port A data, combinational
- rt_data  output  DATA_W  read port B data, combinational
- wb_valid  output  1  pending-latch valid (debug/hazard visibility)
- wb_addr  output  ADDR_W  pending-latch address
- wb_data  output  DATA_W  pending-latch data

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous and active-high.
  - On a rising edge with rst=1: all 32 registers are cleared to 0, and wb_valid, wb_addr and wb_data are cleared to 0.
  - A write pending at reset is discarded and never committed.
- Stage 1, capture (every edge, rst=0)
  - pend_valid <= RegWrite && (reg_write != 0)
  - pend_addr <= reg_write
  - pend_data <= mux(MemtoReg)
  - The latch updates every cycle and does not hold when RegWrite=0.
- Stage 2, commit (same edge, rst=0)
  - If the old pend_valid=1, then regs[old pend_addr] <= old pend_data.
  - Capture and commit happen on the same edge, so back-to-back writes are sustained at one per cycle with no stall.
- Register 0
  - Always reads 0.
  - Writes to address 0 never set pend_valid and never modify regs[0].
- Read ports
  - Purely combinational.
  - Priority order:
    1. Address 0 returns 0.
    2. Otherwise, if pend_valid and pend_addr equals the read address, return pend_data (bypass).
    3. Otherwise return regs[address].
  - rs and rt resolve independently; both may hit the bypass at once.
- Latency
  - A write presented in cycle N is readable through the bypass from cycle N+1.
  - It is in the array from cycle N+2.
  - In cycle N itself, reads return the old value; there is no combinational input-to-output path from reg_write or the data inputs to rs_data or rt_data.
- Ordering and overlap
  - Consecutive writes to the same register: the newer value is in the latch and wins the bypass; the array ends with the newer value one cycle later.
  - A write to register X while the older pending write targets Y: both complete, in order.
- Width rules
  - All data is DATA_W bits with no extension or truncation.
  - MemtoReg=11 is treated as 00.
- Debug outputs: wb_valid, wb_addr and wb_data are direct copies of pend_valid, pend_addr and pend_data.

Test Plan:
- Reset
  - Stimulus: preload registers 1..31 with nonzero values, assert rst for 1 cycle, release.
  - Required: every read returns 0x00000000 and wb_valid=0.
- Basic write
  - Stimulus: RegWrite=1, reg_write=5, MemtoReg=00, alu_result=0xDEADBEEF; rs_addr=5.
  - Required: rs_data=0 in the presentation cycle, 0xDEADBEEF the next cycle via bypass with wb_valid=1, and still 0xDEADBEEF after RegWrite=0 (from the array).
- Source select
  - Stimulus: writes to r31 with MemtoReg=10 and pc_plus4=0x00000104, and to r7 with MemtoReg=01 and mem_data=0x12345678.
  - Required: r31 reads 0x00000104, r7 reads 0x12345678; MemtoReg=11 with alu_result=0xA5A5A5A5 writes 0xA5A5A5A5.
- Register 0
  - Stimulus: RegWrite=1, reg_write=0, alu_result=0xFFFFFFFF.
  - Required: wb_valid stays 0 and rs_addr=0 reads 0 in every cycle.
- Back-to-back writes
  - Stimulus: write r3=0x11 in cycle N, then r3=0x22 in cycle N+1, with rs_addr=rt_addr=3.
  - Required: both ports read 0x11 at N+1, 0x22 at N+2, and 0x22 thereafter.
  - Stimulus: write r3=0x11 then r4=0x44.
  - Required: both registers hold their values afterwards.
- Reset mid-operation
  - Stimulus: write r9=0x99 in cycle N, assert rst in cycle N+1.
  - Required: r9 reads 0 after reset and wb_valid=0.

Source files
------------

// File: rtl/reg_writeback_if.sv
// Write-back bus between the destination-register mux and the register file.
// The producer side drives the write request and read addresses.
interface reg_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] reg_write;
  logic              RegWrite;
  logic [1:0]        MemtoReg;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output reg_write, RegWrite, MemtoReg,
    output alu_result, mem_data, pc_plus4,
    output rs_addr, rt_addr,
    input  rs_data, rt_data,
    input  wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  reg_write, RegWrite, MemtoReg,
    input  alu_result, mem_data, pc_plus4,
    input  rs_addr, rt_addr,
    output rs_data, rt_data,
    output wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/reg_writeback_file.sv
// Register file with a one-entry write-back latch and bypassed read ports.
// Writes become visible through the bypass one cycle after presentation.
module reg_writeback_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input logic            clk,
  input logic            rst,
  reg_writeback_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  if (LINK_REG <= 0 || LINK_REG >= DEPTH) begin : g_link_chk
    $error("LINK_REG outside register range");
  end

  logic [DATA_W-1:0] regs [DEPTH];

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  logic [DATA_W-1:0] wr_data;
  logic              wr_req;

  // MemtoReg=11 falls back to the ALU result
  always_comb begin
    wr_data = bus.alu_result;
    unique case (1'b1)
      (bus.MemtoReg == 2'b01): wr_data = bus.mem_data;
      (bus.MemtoReg == 2'b10): wr_data = bus.pc_plus4;
      default:                 wr_data = bus.alu_result;
    endcase
  end

  assign wr_req = bus.RegWrite && (bus.reg_write != '0);

  // capture and commit share the edge: one write per cycle, no stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      pend_valid <= wr_req;
      pend_addr  <= bus.reg_write;
      pend_data  <= wr_data;
      if (pend_valid) begin
        regs[pend_addr] <= pend_data;
      end
    end
  end

  always_comb begin
    bus.rs_data = regs[bus.rs_addr];
    unique case (1'b1)
      (bus.rs_addr == '0):
        bus.rs_data = '0;
      (pend_valid && pend_addr == bus.rs_addr):
        bus.rs_data = pend_data;
      default:
        bus.rs_data = regs[bus.rs_addr];
    endcase
  end

  always_comb begin
    bus.rt_data = regs[bus.rt_addr];
    unique case (1'b1)
      (bus.rt_addr == '0):
        bus.rt_data = '0;
      (pend_valid && pend_addr == bus.rt_addr):
        bus.rt_data = pend_data;
      default:
        bus.rt_data = regs[bus.rt_addr];
    endcase
  end

  assign bus.wb_valid = pend_valid;
  assign bus.wb_addr  = pend_addr;
  assign bus.wb_data  = pend_data;

endmodule

// File: tb/tb_reg_writeback_file.sv
// Bench for reg_writeback_file: directed plan steps then random traffic
// against an architectural register model.
module tb_reg_writeback_file;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_writeback_if bus ();

  reg_writeback_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // architectural view: a write lands here on the edge it is presented at
  logic [31:0] mdl [32];
  logic        ev;
  logic [4:0]  ea;
  logic [31:0] ed;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] pick(input logic [1:0] s,
                                       input logic [31:0] a,
                                       input logic [31:0] m,
                                       input logic [31:0] p);
    if (s == 2'b01) return m;
    if (s == 2'b10) return p;
    return a;
  endfunction

  task automatic tick();
    logic [31:0] v;
    @(posedge clk);
    v = pick(bus.MemtoReg, bus.alu_result, bus.mem_data, bus.pc_plus4);
    if (rst) begin
      foreach (mdl[i]) mdl[i] = '0;
      ev = 1'b0;
      ea = '0;
      ed = '0;
    end else begin
      if (bus.RegWrite && bus.reg_write != 0) mdl[bus.reg_write] = v;
      ev = bus.RegWrite && (bus.reg_write != 0);
      ea = bus.reg_write;
      ed = v;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_model(input string tag);
    #1;
    chk({tag, ".rs"}, bus.rs_data, mdl[bus.rs_addr]);
    chk({tag, ".rt"}, bus.rt_data, mdl[bus.rt_addr]);
    chk({tag, ".wbv"}, 32'(bus.wb_valid), 32'(ev));
    chk({tag, ".wba"}, 32'(bus.wb_addr), 32'(ea));
    chk({tag, ".wbd"}, bus.wb_data, ed);
  endtask

  task automatic put(input logic we, input logic [4:0] a,
                     input logic [1:0] s, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [31:0] pc);
    bus.RegWrite   = we;
    bus.reg_write  = a;
    bus.MemtoReg   = s;
    bus.alu_result = alu;
    bus.mem_data   = mem;
    bus.pc_plus4   = pc;
  endtask

  task automatic idle();
    put(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.rs_addr = '0;
    bus.rt_addr = '0;
    foreach (mdl[i]) mdl[i] = '0;
    ev = 1'b0; ea = '0; ed = '0;
    tick();
    rst = 1'b0;
    chk_model("rst0");

    // preload then reset
    for (int i = 1; i < 32; i++) begin
      put(1'b1, 5'(i), 2'b00, 32'h01010101 * i + 32'h7, 32'h0, 32'h0);
      tick();
    end
    idle();
    tick();
    bus.rs_addr = 5'd17;
    #1;
    chk("preload", bus.rs_data, 32'h01010101 * 17 + 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(31 - i);
      #1;
      chk("rst_rs", bus.rs_data, 32'h0);
      chk("rst_rt", bus.rt_data, 32'h0);
    end
    chk("rst_wbv", 32'(bus.wb_valid), 32'h0);

    // basic write
    bus.rs_addr = 5'd5;
    put(1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0);
    #1;
    chk("bw_n", bus.rs_data, 32'h0);
    tick();
    idle();
    #1;
    chk("bw_byp", bus.rs_data, 32'hDEADBEEF);
    chk("bw_wbv", 32'(bus.wb_valid), 32'h1);
    tick();
    #1;
    chk("bw_arr", bus.rs_data, 32'hDEADBEEF);
    chk("bw_wbv0", 32'(bus.wb_valid), 32'h0);

    // source select
    put(1'b1, 5'd31, 2'b10, 32'h1, 32'h2, 32'h00000104);
    tick();
    put(1'b1, 5'd7, 2'b01, 32'h1, 32'h12345678, 32'h3);
    tick();
    put(1'b1, 5'd8, 2'b11, 32'hA5A5A5A5, 32'h4, 32'h5);
    tick();
    idle();
    tick();
    bus.rs_addr = 5'd31;
    bus.rt_addr = 5'd7;
    #1;
    chk("sel_pc", bus.rs_data, 32'h00000104);
    chk("sel_mem", bus.rt_data, 32'h12345678);
    bus.rs_addr = 5'd8;
    #1;
    chk("sel_11", bus.rs_data, 32'hA5A5A5A5);

    // register 0
    bus.rs_addr = 5'd0;
    put(1'b1, 5'd0, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("r0_rd", bus.rs_data, 32'h0);
      chk("r0_wbv", 32'(bus.wb_valid), 32'h0);
      tick();
    end
    idle();

    // back-to-back same register
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd3;
    put(1'b1, 5'd3, 2'b00, 32'h11, 32'h0, 32'h0);
    tick();
    put(1'b1, 5'd3, 2'b00, 32'h22, 32'h0, 32'h0);
    #1;
    chk("b2b_n1_rs", bus.rs_data, 32'h11);
    chk("b2b_n1_rt", bus.rt_data, 32'h11);
    tick();
    idle();
    #1;
    chk("b2b_n2_rs", bus.rs_data, 32'h22);
    chk("b2b_n2_rt", bus.rt_data, 32'h22);
    tick();
    #1;
    chk("b2b_n3", bus.rs_data, 32'h22);

    // back-to-back different registers
    put(1'b1, 5'd3, 2'b00, 32'h11, 32'h0, 32'h0);
    tick();
    put(1'b1, 5'd4, 2'b00, 32'h44, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd4;
    #1;
    chk("b2b_r3", bus.rs_data, 32'h11);
    chk("b2b_r4", bus.rt_data, 32'h44);

    // reset mid-operation
    bus.rs_addr = 5'd9;
    put(1'b1, 5'd9, 2'b00, 32'h99, 32'h0, 32'h0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("rstmid_r9", bus.rs_data, 32'h0);
    chk("rstmid_wbv", 32'(bus.wb_valid), 32'h0);
    chk_model("rstmid");

    // random traffic, addresses biased low to hit the bypass often
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      put(1'($urandom), a, 2'($urandom), $urandom, $urandom, $urandom);
      bus.rs_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      bus.rt_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      rst = ($urandom_range(0, 60) == 0);
      chk_model("rand");
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(i ^ 5'h1f);
      chk_model("final");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
